// File: rtl/sci_pulse_gen_pkg.sv
// Shared constants for the scientific-notation pulse generator: FSM encodings,
// BCD digit values and a digit validity helper.
package sci_pulse_gen_pkg;

    localparam logic [1:0] SPG_IDLE = 2'd0;
    localparam logic [1:0] SPG_RUN  = 2'd1;
    localparam logic [1:0] SPG_DONE = 2'd2;

    localparam logic [3:0] BCD_0  = 4'd0;
    localparam logic [3:0] BCD_1  = 4'd1;
    localparam logic [3:0] BCD_2  = 4'd2;
    localparam logic [3:0] BCD_3  = 4'd3;
    localparam logic [3:0] BCD_4  = 4'd4;
    localparam logic [3:0] BCD_5  = 4'd5;
    localparam logic [3:0] BCD_6  = 4'd6;
    localparam logic [3:0] BCD_7  = 4'd7;
    localparam logic [3:0] BCD_8  = 4'd8;
    localparam logic [3:0] BCD_9  = 4'd9;
    localparam logic [3:0] BCD_10 = 4'd10;

    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit < BCD_10);
    endfunction

endpackage

// File: rtl/sci_pulse_gen_if.sv
// Control, status and remaining-count display bundle of the pulse generator.
interface sci_pulse_gen_if;

    logic       start;
    logic       abort;
    logic       step;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic [3:0] exp_digit;
    logic       pulse;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] rem_tens;
    logic [3:0] rem_ones;
    logic [3:0] rem_exp;

    modport master (
        output start, abort, step, tens_digit, ones_digit, exp_digit,
        input  pulse, busy, done, err, rem_tens, rem_ones, rem_exp
    );

    modport slave (
        input  start, abort, step, tens_digit, ones_digit, exp_digit,
        output pulse, busy, done, err, rem_tens, rem_ones, rem_exp
    );

endinterface

// File: rtl/sci_pulse_gen_bcd_dec_digit.sv
// One decade of the BCD down-counter: parallel load, decrement on incoming
// borrow, and borrow-out when a decrement has to wrap 0 to 9.
module sci_pulse_gen_bcd_dec_digit
    import sci_pulse_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_d;
    logic [3:0] digit_q;
    logic       dec_s;

    // Next decade value: load wins over decrement.
    always_comb begin
        dec_s   = dec_en & borrow_in;
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec_s) begin
            digit_d = (digit_q == BCD_0) ? BCD_9 : (digit_q - 4'd1);
        end else begin
            digit_d = digit_q;
        end
    end

    // Decade register.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = (digit_q == BCD_0) & dec_s;

endmodule

// File: rtl/sci_pulse_gen.sv
// Emits (10*T+O)*10^E paced enable pulses from a BCD down-counter and shows
// the remaining count in normalized XXEY form.
module sci_pulse_gen
    import sci_pulse_gen_pkg::*;
#(
    parameter int N_DIGITS = 11
) (
    input  logic            clk,
    input  logic            rst,
    sci_pulse_gen_if.slave  bus
);

    localparam logic [3:0] MAX_EXP = 4'(N_DIGITS - 2);

    logic [1:0] state_d;
    logic [1:0] state_q;
    logic       pulse_d;
    logic       pulse_q;
    logic       busy_d;
    logic       busy_q;
    logic       done_d;
    logic       done_q;
    logic       err_d;
    logic       err_q;

    logic [N_DIGITS-1:0][3:0] digit_s;
    logic [N_DIGITS-1:0][3:0] load_val_s;
    logic [N_DIGITS:0]        borrow_s;
    logic                     unused_borrow_s;

    logic       start_bad_s;
    logic       mant_zero_s;
    logic       upper_zero_s;
    logic       is_one_s;
    logic       load_s;
    logic       clear_s;
    logic       digit_load_s;
    logic       dec_s;
    logic [3:0] rem_exp_s;
    logic [3:0] rem_ones_s;
    logic [3:0] rem_tens_s;

    // Start validation and "count equals one" detection for the last decrement.
    always_comb begin
        start_bad_s = ~is_bcd(bus.tens_digit) | ~is_bcd(bus.ones_digit)
                    | ~is_bcd(bus.exp_digit)  | (bus.exp_digit > MAX_EXP);
        mant_zero_s = (bus.tens_digit == BCD_0) & (bus.ones_digit == BCD_0);
        upper_zero_s = 1'b1;
        for (int i = 1; i < N_DIGITS; i++) begin
            upper_zero_s = upper_zero_s & (digit_s[i] == BCD_0);
        end
        is_one_s = upper_zero_s & (digit_s[0] == BCD_1);
    end

    // Sequencer: IDLE accepts a start, RUN counts down on step, DONE is a single cycle.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        load_s  = 1'b0;
        clear_s = 1'b0;
        dec_s   = 1'b0;
        case (state_q)
            SPG_IDLE: begin
                if (bus.start) begin
                    if (start_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d  = 1'b0;
                        load_s = 1'b1;
                        if (mant_zero_s) begin
                            state_d = SPG_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SPG_RUN;
                        end
                    end
                end else begin
                    state_d = SPG_IDLE;
                end
            end
            SPG_RUN: begin
                if (bus.abort) begin
                    state_d = SPG_IDLE;
                    clear_s = 1'b1;
                end else if (bus.step) begin
                    dec_s   = 1'b1;
                    pulse_d = 1'b1;
                    if (is_one_s) begin
                        state_d = SPG_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SPG_RUN;
                    end
                end else begin
                    state_d = SPG_RUN;
                end
            end
            SPG_DONE: begin
                state_d = SPG_IDLE;
            end
            default: begin
                state_d = SPG_IDLE;
            end
        endcase
        busy_d = (state_d == SPG_RUN);
    end

    // Per-decade load value: mantissa placed at decades E and E+1, zeros elsewhere.
    always_comb begin
        load_val_s = {N_DIGITS{BCD_0}};
        for (int i = 0; i < N_DIGITS; i++) begin
            if (clear_s) begin
                load_val_s[i] = BCD_0;
            end else if (4'(i) == bus.exp_digit) begin
                load_val_s[i] = bus.ones_digit;
            end else if (4'(i) == (bus.exp_digit + 4'd1)) begin
                load_val_s[i] = bus.tens_digit;
            end else begin
                load_val_s[i] = BCD_0;
            end
        end
    end

    assign digit_load_s    = load_s | clear_s;
    assign borrow_s[0]     = 1'b1;
    // The chain never borrows past the top decade because RUN exits at zero.
    assign unused_borrow_s = borrow_s[N_DIGITS];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_decade
        sci_pulse_gen_bcd_dec_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (digit_load_s),
            .load_val   (load_val_s[g]),
            .dec_en     (dec_s),
            .borrow_in  (borrow_s[g]),
            .digit      (digit_s[g]),
            .borrow_out (borrow_s[g+1])
        );
    end

    // Normalize: exponent sits one below the highest nonzero decade, floor 0.
    always_comb begin
        rem_exp_s = 4'd0;
        for (int i = 2; i < N_DIGITS; i++) begin
            rem_exp_s = (digit_s[i] != BCD_0) ? 4'(i - 1) : rem_exp_s;
        end
        rem_ones_s = digit_s[rem_exp_s];
        rem_tens_s = digit_s[rem_exp_s + 4'd1];
    end

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SPG_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.pulse    = pulse_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rem_tens = rem_tens_s;
    assign bus.rem_ones = rem_ones_s;
    assign bus.rem_exp  = rem_exp_s;

endmodule

// File: tb/tb_sci_pulse_gen.sv
// Directed self-checking bench for sci_pulse_gen.
module tb_sci_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   pcount;
    logic done_seen;

    sci_pulse_gen_if bus ();

    sci_pulse_gen #(.N_DIGITS(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Display form of an integer count: {tens, ones, exp}.
    function automatic logic [11:0] disp(input longint n);
        logic [3:0] d [11];
        longint     m;
        int         e;
        m = n;
        for (int i = 0; i < 11; i++) begin
            d[i] = 4'(m % 10);
            m    = m / 10;
        end
        e = 0;
        for (int i = 2; i < 11; i++) begin
            if (d[i] != 4'd0) e = i - 1;
        end
        return {d[e+1], d[e], 4'(e)};
    endfunction

    function automatic logic [11:0] rem();
        return {bus.rem_tens, bus.rem_ones, bus.rem_exp};
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_pulse"}, bus.pulse, 1'b0);
        chk({tag, "_busy"},  bus.busy,  1'b0);
        chk({tag, "_done"},  bus.done,  1'b0);
        chk({tag, "_err"},   bus.err,   1'b0);
        chk({tag, "_rem"},   rem(),     12'h000);
    endtask

    task automatic start_run(input logic [3:0] t, input logic [3:0] o, input logic [3:0] e);
        bus.tens_digit = t;
        bus.ones_digit = o;
        bus.exp_digit  = e;
        bus.start      = 1'b1;
        cyc();
        bus.start      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.step = 1'b0;
        bus.tens_digit = 4'd0; bus.ones_digit = 4'd0; bus.exp_digit = 4'd0;
        cyc(); cyc();
        chk_idle_zero("rst_hold");
        rst = 1'b0;
        cyc();
        chk_idle_zero("rst_rel");

        // 12 pulses with step held high
        bus.step = 1'b1;
        start_run(4'd1, 4'd2, 4'd0);
        chk("t1_load_rem", rem(), 12'h120);
        chk("t1_load_busy", bus.busy, 1'b1);
        chk("t1_load_pulse", bus.pulse, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("t1_pulse", bus.pulse, 1'b1);
            chk("t1_rem", rem(), disp(longint'(12 - k)));
            chk("t1_done", bus.done, 1'(k == 12));
            chk("t1_busy", bus.busy, 1'(k != 12));
        end
        cyc();
        chk("t1_after_done", bus.done, 1'b0);
        chk("t1_after_pulse", bus.pulse, 1'b0);

        // 25E1 = 250 pulses
        start_run(4'd2, 4'd5, 4'd1);
        chk("t2_load_rem", rem(), 12'h251);
        pcount = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            cyc();
            if (bus.pulse) pcount++;
            if (bus.pulse && pcount == 1)   chk("t2_rem_249", rem(), 12'h241);
            if (bus.pulse && pcount == 160) chk("t2_rem_90",  rem(), 12'h900);
            if (bus.done) done_seen = 1'b1;
        end
        chk("t2_pulses", 64'(pcount), 64'd250);
        chk("t2_done_seen", done_seen, 1'b1);
        cyc();

        // 3 pulses with step alternating 0,1
        bus.step = 1'b0;
        start_run(4'd0, 4'd3, 4'd0);
        pcount = 0;
        for (int j = 1; j <= 6; j++) begin
            bus.step = 1'((j % 2) == 0);
            cyc();
            if (bus.pulse) pcount++;
            chk("t3_pulse", bus.pulse, 1'((j % 2) == 0));
            chk("t3_done", bus.done, 1'(j == 6));
            chk("t3_busy", bus.busy, 1'(j != 6));
        end
        chk("t3_pulses", 64'(pcount), 64'd3);
        bus.step = 1'b0;
        cyc();
        chk("t3_idle_busy", bus.busy, 1'b0);

        // zero mantissa goes straight to DONE
        bus.step = 1'b1;
        start_run(4'd0, 4'd0, 4'd5);
        chk("t4_done", bus.done, 1'b1);
        chk("t4_busy", bus.busy, 1'b0);
        chk("t4_pulse", bus.pulse, 1'b0);
        cyc();
        chk("t4_done_end", bus.done, 1'b0);
        chk("t4_busy_end", bus.busy, 1'b0);
        chk("t4_pulse_end", bus.pulse, 1'b0);

        // illegal starts set sticky err, valid start clears it
        start_run(4'd1, 4'hA, 4'd0);
        chk("t5_bcd_err", bus.err, 1'b1);
        chk("t5_bcd_busy", bus.busy, 1'b0);
        chk("t5_bcd_pulse", bus.pulse, 1'b0);
        cyc();
        chk("t5_err_sticky", bus.err, 1'b1);
        start_run(4'd1, 4'd1, 4'd10);
        chk("t5_exp_err", bus.err, 1'b1);
        chk("t5_exp_busy", bus.busy, 1'b0);
        chk("t5_exp_rem", rem(), 12'h000);
        start_run(4'd0, 4'd1, 4'd0);
        chk("t5_ok_err", bus.err, 1'b0);
        chk("t5_ok_busy", bus.busy, 1'b1);
        cyc();
        chk("t5_ok_pulse", bus.pulse, 1'b1);
        chk("t5_ok_done", bus.done, 1'b1);
        chk("t5_ok_busy_done", bus.busy, 1'b0);
        cyc();
        chk("t5_ok_pulse_end", bus.pulse, 1'b0);
        chk("t5_ok_done_end", bus.done, 1'b0);

        // 99E9: restart ignored in RUN, abort clears
        bus.step = 1'b1;
        start_run(4'd9, 4'd9, 4'd9);
        chk("t6_load_rem", rem(), 12'h999);
        repeat (5) cyc();
        chk("t6_pulse5", bus.pulse, 1'b1);
        chk("t6_rem5", rem(), 12'h989);
        bus.step = 1'b0;
        start_run(4'd1, 4'd1, 4'd0);
        chk("t6_restart_busy", bus.busy, 1'b1);
        chk("t6_restart_pulse", bus.pulse, 1'b0);
        chk("t6_restart_err", bus.err, 1'b0);
        chk("t6_restart_rem", rem(), 12'h989);
        bus.abort = 1'b1;
        bus.step  = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk_idle_zero("t6_abort");
        cyc();
        chk("t6_abort_done", bus.done, 1'b0);

        // abort in IDLE does not block a start
        bus.step  = 1'b0;
        bus.abort = 1'b1;
        start_run(4'd0, 4'd2, 4'd0);
        bus.abort = 1'b0;
        chk("t7_busy", bus.busy, 1'b1);
        chk("t7_rem", rem(), 12'h020);
        bus.step = 1'b1;
        cyc();
        chk("t7_pulse1", bus.pulse, 1'b1);
        cyc();
        chk("t7_done", bus.done, 1'b1);

        // rst mid-run
        cyc();
        start_run(4'd9, 4'd9, 4'd9);
        repeat (5) cyc();
        chk("t8_pulse5", bus.pulse, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle_zero("t8_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
